// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Two-requester front end for a single-port, word-indexed data memory that
// has no byte enables. Requester 0 is the core load/store unit and requester 1
// is the debug/DMA port. The block picks one request at a time, checks it for
// legality, performs sub-word stores as read-modify-write, and sign/zero-extends
// sub-word loads before returning them.
//
// Ports:
//   i_clk, i_rst            rising-edge clock, asynchronous active-high reset
//   i_rN_req/we/addr/wdata  request, store flag, byte address, right-aligned data
//   i_rN_size/unsigned      00 byte, 01 half, 10 word, 11 illegal; zero-extend loads
//   o_rN_gnt                request accepted this cycle (combinational, IDLE only)
//   o_rN_rvalid/err         one-cycle completion pulse, error flag alongside it
//   o_rN_rdata              extended load data, held until the next load to N
//   o_mem_addr/wdata/we     word index, write word and write enable to memory
//   i_mem_rdata             combinational read data for o_mem_addr
module dmem_arbiter #(
  parameter int DEPTH      = 64,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_r0_req,
  input  logic        i_r0_we,
  input  logic [31:0] i_r0_addr,
  input  logic [31:0] i_r0_wdata,
  input  logic [1:0]  i_r0_size,
  input  logic        i_r0_unsigned,
  output logic        o_r0_gnt,
  output logic        o_r0_rvalid,
  output logic [31:0] o_r0_rdata,
  output logic        o_r0_err,
  input  logic        i_r1_req,
  input  logic        i_r1_we,
  input  logic [31:0] i_r1_addr,
  input  logic [31:0] i_r1_wdata,
  input  logic [1:0]  i_r1_size,
  input  logic        i_r1_unsigned,
  output logic        o_r1_gnt,
  output logic        o_r1_rvalid,
  output logic [31:0] o_r1_rdata,
  output logic        o_r1_err,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic        o_mem_we,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WR, ERR} state_t;

  localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH);

  state_t      state, state_nxt;
  logic        rr_last;
  logic        owner;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [1:0]  lat_size;
  logic        lat_uns;
  logic [31:0] merged;

  logic        grant, win;
  logic        sel_we, sel_uns, sel_bad;
  logic [31:0] sel_addr, sel_wdata;
  logic [1:0]  sel_size;

  logic [4:0]  lane_sh;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_val, lane_mask, lane_data, merge_val;

  // Arbitration: a lone requester always wins. With both requesting, the
  // round-robin pointer (rr_last, the id granted most recently) hands the
  // grant to the other one, unless fixed priority pins it to r0. The chosen
  // request is then screened for illegal size, misalignment and range.
  always_comb begin
    win = 1'b0;
    if (i_r0_req && i_r1_req) begin
      win = FIXED_PRIO ? 1'b0 : ~rr_last;
    end else if (i_r1_req) begin
      win = 1'b1;
    end
    grant     = (state == IDLE) && (i_r0_req || i_r1_req) && !i_rst;
    sel_we    = win ? i_r1_we       : i_r0_we;
    sel_addr  = win ? i_r1_addr     : i_r0_addr;
    sel_wdata = win ? i_r1_wdata    : i_r0_wdata;
    sel_size  = win ? i_r1_size     : i_r0_size;
    sel_uns   = win ? i_r1_unsigned : i_r0_unsigned;
    sel_bad   = (sel_size == 2'b11)
             || ((sel_size == 2'b01) && sel_addr[0])
             || ((sel_size == 2'b10) && (sel_addr[1:0] != 2'b00))
             || ({1'b0, sel_addr} >= ADDR_LIMIT);
    o_r0_gnt  = grant && !win;
    o_r1_gnt  = grant && win;
  end

  // Next-state logic. Only byte/half stores need the extra MERGE_WR cycle,
  // because the old word must be read before the merged word can be written.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (grant) state_nxt = sel_bad ? ERR : ACCESS;
      ACCESS:   state_nxt = (lat_we && (lat_size != 2'b10)) ? MERGE_WR : IDLE;
      MERGE_WR: state_nxt = IDLE;
      ERR:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Lane extraction for loads and lane merging for sub-word stores, both
  // working on the word currently returned by memory at the latched address.
  always_comb begin
    lane_sh = {lat_addr[1:0], 3'b000};
    case (lat_addr[1:0])
      2'd0:    byte_lane = i_mem_rdata[7:0];
      2'd1:    byte_lane = i_mem_rdata[15:8];
      2'd2:    byte_lane = i_mem_rdata[23:16];
      default: byte_lane = i_mem_rdata[31:24];
    endcase
    half_lane = lat_addr[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    case (lat_size)
      2'b00:   load_val = lat_uns ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      2'b01:   load_val = lat_uns ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
      default: load_val = i_mem_rdata;
    endcase
    lane_mask = ((lat_size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << lane_sh;
    lane_data = (lat_wdata & ((lat_size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF)) << lane_sh;
    merge_val = (i_mem_rdata & ~lane_mask) | lane_data;
  end

  // Memory port drive. The address is only presented while an access is in
  // flight, and the write enable is confined to a word store in ACCESS or the
  // write-back half of a read-modify-write.
  always_comb begin
    o_mem_addr  = 32'h0;
    o_mem_wdata = 32'h0;
    o_mem_we    = 1'b0;
    if ((state == ACCESS) || (state == MERGE_WR)) begin
      o_mem_addr = {2'b00, lat_addr[31:2]};
    end
    if ((state == ACCESS) && lat_we && (lat_size == 2'b10)) begin
      o_mem_we    = 1'b1;
      o_mem_wdata = lat_wdata;
    end
    if (state == MERGE_WR) begin
      o_mem_we    = 1'b1;
      o_mem_wdata = merged;
    end
  end

  // State, request latch and response registers. Completion is signalled on
  // the transition back to IDLE so every access reports exactly once; reset
  // drops any access in flight without a write or a completion pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      rr_last     <= 1'b1;
      owner       <= 1'b0;
      lat_we      <= 1'b0;
      lat_addr    <= 32'h0;
      lat_wdata   <= 32'h0;
      lat_size    <= 2'b00;
      lat_uns     <= 1'b0;
      merged      <= 32'h0;
      o_r0_rvalid <= 1'b0;
      o_r1_rvalid <= 1'b0;
      o_r0_err    <= 1'b0;
      o_r1_err    <= 1'b0;
      o_r0_rdata  <= 32'h0;
      o_r1_rdata  <= 32'h0;
    end else begin
      state       <= state_nxt;
      o_r0_rvalid <= 1'b0;
      o_r1_rvalid <= 1'b0;
      o_r0_err    <= 1'b0;
      o_r1_err    <= 1'b0;
      if (grant) begin
        rr_last   <= win;
        owner     <= win;
        lat_we    <= sel_we;
        lat_addr  <= sel_addr;
        lat_wdata <= sel_wdata;
        lat_size  <= sel_size;
        lat_uns   <= sel_uns;
      end
      if ((state == ACCESS) && !lat_we) begin
        if (owner) o_r1_rdata <= load_val;
        else       o_r0_rdata <= load_val;
      end
      if ((state == ACCESS) && lat_we) begin
        merged <= merge_val;
      end
      if ((state != IDLE) && (state_nxt == IDLE)) begin
        if (owner) begin
          o_r1_rvalid <= 1'b1;
          o_r1_err    <= (state == ERR);
        end else begin
          o_r0_rvalid <= 1'b1;
          o_r0_err    <= (state == ERR);
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Directed and randomized accesses against dmem_arbiter. A byte-addressed
// reference memory predicts load results, store effects, latency and errors.
// A second instance with fixed priority covers r1 starvation.
module tb_dmem_arbiter;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_req, r0_we, r0_uns, r1_req, r1_we, r1_uns;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic [1:0]  r0_size, r1_size;
  logic        r0_gnt, r0_rvalid, r0_err, r1_gnt, r1_rvalid, r1_err;
  logic [31:0] r0_rdata, r1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  logic        fp_r0_req, fp_r1_req;
  logic        fp_r0_gnt, fp_r0_rvalid, fp_r0_err, fp_r1_gnt, fp_r1_rvalid, fp_r1_err;
  logic [31:0] fp_r0_rdata, fp_r1_rdata, fp_mem_addr, fp_mem_wdata;
  logic        fp_mem_we;

  logic [31:0] mem [DEPTH];
  logic [7:0]  ref_b [4*DEPTH];
  logic [31:0] ref_rdata [2];
  int          last_rid;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DEPTH(DEPTH), .FIXED_PRIO(1'b0)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_r0_req(r0_req), .i_r0_we(r0_we), .i_r0_addr(r0_addr), .i_r0_wdata(r0_wdata),
    .i_r0_size(r0_size), .i_r0_unsigned(r0_uns),
    .o_r0_gnt(r0_gnt), .o_r0_rvalid(r0_rvalid), .o_r0_rdata(r0_rdata), .o_r0_err(r0_err),
    .i_r1_req(r1_req), .i_r1_we(r1_we), .i_r1_addr(r1_addr), .i_r1_wdata(r1_wdata),
    .i_r1_size(r1_size), .i_r1_unsigned(r1_uns),
    .o_r1_gnt(r1_gnt), .o_r1_rvalid(r1_rvalid), .o_r1_rdata(r1_rdata), .o_r1_err(r1_err),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_we(mem_we),
    .i_mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.DEPTH(DEPTH), .FIXED_PRIO(1'b1)) dut_fp (
    .i_clk(clk), .i_rst(rst),
    .i_r0_req(fp_r0_req), .i_r0_we(r0_we), .i_r0_addr(r0_addr), .i_r0_wdata(r0_wdata),
    .i_r0_size(r0_size), .i_r0_unsigned(r0_uns),
    .o_r0_gnt(fp_r0_gnt), .o_r0_rvalid(fp_r0_rvalid), .o_r0_rdata(fp_r0_rdata), .o_r0_err(fp_r0_err),
    .i_r1_req(fp_r1_req), .i_r1_we(r1_we), .i_r1_addr(r1_addr), .i_r1_wdata(r1_wdata),
    .i_r1_size(r1_size), .i_r1_unsigned(r1_uns),
    .o_r1_gnt(fp_r1_gnt), .o_r1_rvalid(fp_r1_rvalid), .o_r1_rdata(fp_r1_rdata), .o_r1_err(fp_r1_err),
    .o_mem_addr(fp_mem_addr), .o_mem_wdata(fp_mem_wdata), .o_mem_we(fp_mem_we),
    .i_mem_rdata(32'h0)
  );

  // Behavioural single-port memory with combinational read.
  assign mem_rdata = (mem_addr < 32'(DEPTH)) ? mem[mem_addr[5:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_we && (mem_addr < 32'(DEPTH))) mem[mem_addr[5:0]] <= mem_wdata;
  end

  // Watchdog so the run always ends even if the design locks up.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] ref_word(input int w);
    return {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
  endfunction

  function automatic bit is_bad(input logic [31:0] addr, input logic [1:0] size);
    if (size == 2'b11) return 1'b1;
    if (addr >= 32'(4*DEPTH)) return 1'b1;
    if (size == 2'b01 && (addr % 2) != 0) return 1'b1;
    if (size == 2'b10 && (addr % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size, input logic uns);
    int n = 1 << size;
    int a = int'(addr);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < n; i++) v = v + (32'(ref_b[a+i]) << (8*i));
    if (!uns && n < 4 && v >= (32'h1 << (8*n - 1))) v = v - (32'h1 << (8*n));
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] addr, input logic [31:0] wdata, input logic [1:0] size);
    int n = 1 << size;
    int a = int'(addr);
    for (int i = 0; i < n; i++) ref_b[a+i] = 8'((wdata >> (8*i)) & 32'hFF);
  endtask

  task automatic setReq(input int rid, input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] size, input logic uns);
    if (rid == 0) begin
      r0_req = req; r0_we = we; r0_addr = addr; r0_wdata = wdata; r0_size = size; r0_uns = uns;
    end else begin
      r1_req = req; r1_we = we; r1_addr = addr; r1_wdata = wdata; r1_size = size; r1_uns = uns;
    end
  endtask

  function automatic logic gnt_of(input int rid);
    return (rid == 0) ? r0_gnt : r1_gnt;
  endfunction
  function automatic logic rvalid_of(input int rid);
    return (rid == 0) ? r0_rvalid : r1_rvalid;
  endfunction
  function automatic logic err_of(input int rid);
    return (rid == 0) ? r0_err : r1_err;
  endfunction
  function automatic logic [31:0] rdata_of(input int rid);
    return (rid == 0) ? r0_rdata : r1_rdata;
  endfunction

  // One complete access from a single requester: wait for the grant, then
  // check latency, response, write activity and the resulting memory word.
  task automatic applyStimulus(input int rid, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [1:0] size, input logic uns);
    bit          bad;
    int          exp_lat, exp_we_lat, lat, we_cnt, we_lat, waited;
    logic [31:0] exp_rdata;
    bad = is_bad(addr, size);
    if (bad)                  begin exp_lat = 2; exp_we_lat = 0; end
    else if (we && size == 2) begin exp_lat = 2; exp_we_lat = 1; end
    else if (we)              begin exp_lat = 3; exp_we_lat = 2; end
    else                      begin exp_lat = 2; exp_we_lat = 0; end
    exp_rdata = ref_rdata[rid];
    if (!bad && !we) exp_rdata = ref_load(addr, size, uns);

    @(negedge clk);
    setReq(rid, 1'b1, we, addr, wdata, size, uns);
    #1;
    waited = 0;
    while (!gnt_of(rid) && waited < 8) begin
      @(negedge clk); #1; waited++;
    end
    checkOutput($sformatf("gnt r%0d a=%h", rid, addr), 32'(gnt_of(rid)), 32'h1);
    checkOutput($sformatf("gnt_other r%0d", rid), 32'(gnt_of(1-rid)), 32'h0);
    @(negedge clk);
    r0_req = 1'b0; r1_req = 1'b0;
    #1;
    lat = 1; we_cnt = 0; we_lat = 0;
    while (!rvalid_of(rid) && lat < 6) begin
      if (mem_we) begin we_cnt++; we_lat = lat; end
      @(negedge clk); #1; lat++;
    end
    checkOutput($sformatf("rvalid_lat r%0d a=%h", rid, addr), 32'(lat), 32'(exp_lat));
    checkOutput($sformatf("rvalid_other r%0d", rid), 32'(rvalid_of(1-rid)), 32'h0);
    checkOutput($sformatf("err r%0d a=%h s=%0d", rid, addr, size), 32'(err_of(rid)), 32'(bad));
    checkOutput($sformatf("rdata r%0d a=%h", rid, addr), rdata_of(rid), exp_rdata);
    checkOutput($sformatf("we_count a=%h", addr), 32'(we_cnt), 32'(exp_we_lat != 0));
    if (exp_we_lat != 0) checkOutput($sformatf("we_cycle a=%h", addr), 32'(we_lat), 32'(exp_we_lat));
    if (!bad && we) ref_store(addr, wdata, size);
    ref_rdata[rid] = exp_rdata;
    if (addr < 32'(4*DEPTH))
      checkOutput($sformatf("mem_word a=%h", addr), mem[6'(addr >> 2)], ref_word(int'(addr >> 2)));
    last_rid = rid;
  endtask

  initial begin
    int          waited, exp_win, prev, cnt0, cnt1, cnt1v, rv;
    logic        rwe, runs;
    logic [1:0]  rsize;
    logic [31:0] raddr;
    int          rrid, rsel;

    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
    for (int i = 0; i < 4*DEPTH; i++) ref_b[i] = 8'h0;
    ref_rdata[0] = 32'h0; ref_rdata[1] = 32'h0;
    last_rid = 1;
    rst = 1'b1;
    fp_r0_req = 1'b0; fp_r1_req = 1'b0;
    setReq(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    setReq(1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_ctrl", {25'h0, r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_err, r1_err, mem_we}, 32'h0);
    checkOutput("reset_rdata0", r0_rdata, 32'h0);
    checkOutput("reset_mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    $display("[TB] reset released");

    // Word store then load, r0.
    applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0);
    checkOutput("sw_const", mem[4], 32'hDEADBEEF);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
    checkOutput("lw_const", r0_rdata, 32'hDEADBEEF);

    // Sub-word read-modify-write.
    applyStimulus(0, 1'b1, 32'h10, 32'h11223344, 2'b10, 1'b0);
    applyStimulus(0, 1'b1, 32'h13, 32'h000000AA, 2'b00, 1'b0);
    checkOutput("sb_const", mem[4], 32'hAA223344);

    // Load extension.
    applyStimulus(1, 1'b1, 32'h10, 32'h0000F080, 2'b10, 1'b0);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 2'b00, 1'b0);
    checkOutput("lb_const", r0_rdata, 32'hFFFFFF80);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 2'b00, 1'b1);
    checkOutput("lbu_const", r0_rdata, 32'h00000080);
    applyStimulus(1, 1'b0, 32'h10, 32'h0, 2'b01, 1'b0);
    checkOutput("lh_const", r1_rdata, 32'hFFFFF080);

    // Error cases: rdata must be left untouched.
    applyStimulus(0, 1'b0, 32'h12, 32'h0, 2'b10, 1'b0);
    applyStimulus(0, 1'b0, 32'h11, 32'h0, 2'b01, 1'b0);
    applyStimulus(1, 1'b0, 32'h10, 32'h0, 2'b11, 1'b0);
    applyStimulus(0, 1'b1, 32'h100, 32'h12345678, 2'b10, 1'b0);
    checkOutput("err_rdata_hold", r0_rdata, 32'h00000080);

    // Randomized accesses from either requester.
    for (int k = 0; k < 40; k++) begin
      rrid  = int'($urandom_range(0, 1));
      rwe   = 1'($urandom_range(0, 1));
      runs  = 1'($urandom_range(0, 1));
      rsel  = int'($urandom_range(0, 9));
      rsize = (rsel < 3) ? 2'b00 : (rsel < 6) ? 2'b01 : (rsel < 9) ? 2'b10 : 2'b11;
      raddr = 32'($urandom_range(0, 4*DEPTH - 1));
      if ($urandom_range(0, 3) != 0 && rsize != 2'b11) raddr = raddr & ~((32'h1 << rsize) - 32'h1);
      if ($urandom_range(0, 9) == 0) raddr = 32'(4*DEPTH) + 32'($urandom_range(0, 255));
      applyStimulus(rrid, rwe, raddr, $urandom, rsize, runs);
    end

    // Round-robin with both requesters held.
    @(negedge clk);
    setReq(0, 1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
    setReq(1, 1'b1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0);
    #1;
    exp_win = 1 - last_rid;
    prev = 0;
    for (int k = 0; k < 6; k++) begin
      waited = 0;
      while (!r0_gnt && !r1_gnt && waited < 8) begin
        @(negedge clk); #1; waited++;
      end
      checkOutput($sformatf("rr_gnt%0d", k), {30'h0, r1_gnt, r0_gnt}, (exp_win == 1) ? 32'h2 : 32'h1);
      if (k > 0) begin
        checkOutput($sformatf("rr_gap%0d", k), 32'(waited), 32'h1);
        checkOutput($sformatf("rr_rvalid%0d", k), {30'h0, r1_rvalid, r0_rvalid}, (prev == 1) ? 32'h2 : 32'h1);
        checkOutput($sformatf("rr_rdata%0d", k), rdata_of(prev), ref_word((prev == 1) ? 8 : 4));
      end
      prev = exp_win;
      exp_win = 1 - exp_win;
      if (k < 5) begin
        @(negedge clk); #1;
      end
    end
    @(negedge clk);
    r0_req = 1'b0; r1_req = 1'b0;
    #1;
    waited = 0;
    while (!rvalid_of(prev) && waited < 6) begin
      @(negedge clk); #1; waited++;
    end
    checkOutput("rr_last_rvalid", 32'(rvalid_of(prev)), 32'h1);
    ref_rdata[0] = ref_word(4);
    ref_rdata[1] = ref_word(8);
    last_rid = prev;

    // Fixed priority: r1 starves while r0 keeps requesting.
    @(negedge clk);
    setReq(0, 1'b0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
    setReq(1, 1'b0, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0);
    fp_r0_req = 1'b1; fp_r1_req = 1'b1;
    cnt0 = 0; cnt1 = 0; cnt1v = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (fp_r0_gnt) cnt0++;
      if (fp_r1_gnt) cnt1++;
      if (fp_r1_rvalid) cnt1v++;
      @(negedge clk);
    end
    fp_r0_req = 1'b0; fp_r1_req = 1'b0;
    checkOutput("fp_r0_grants", 32'(cnt0), 32'd5);
    checkOutput("fp_r1_grants", 32'(cnt1), 32'd0);
    checkOutput("fp_r1_rvalids", 32'(cnt1v), 32'd0);
    repeat (3) @(negedge clk);

    // Reset in the middle of a half-word read-modify-write.
    applyStimulus(0, 1'b1, 32'h10, 32'h11223344, 2'b10, 1'b0);
    @(negedge clk);
    setReq(0, 1'b1, 1'b1, 32'h12, 32'h00005555, 2'b01, 1'b0);
    #1;
    waited = 0;
    while (!r0_gnt && waited < 8) begin
      @(negedge clk); #1; waited++;
    end
    checkOutput("rst_sh_gnt", 32'(r0_gnt), 32'h1);
    @(negedge clk);
    r0_req = 1'b0;
    #1;
    checkOutput("rst_sh_access_we", 32'(mem_we), 32'h0);
    @(negedge clk);
    #1;
    checkOutput("rst_sh_merge_we", 32'(mem_we), 32'h1);
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_ctrl", {25'h0, r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_err, r1_err, mem_we}, 32'h0);
    checkOutput("rst_mid_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_mid_mem_wdata", mem_wdata, 32'h0);
    checkOutput("rst_mid_rdata0", r0_rdata, 32'h0);
    checkOutput("rst_mid_rdata1", r1_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    ref_rdata[0] = 32'h0; ref_rdata[1] = 32'h0;
    last_rid = 1;
    checkOutput("rst_mid_mem_word", mem[4], ref_word(4));
    rv = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (r0_rvalid || r1_rvalid) rv++;
      @(negedge clk);
    end
    checkOutput("rst_no_rvalid", 32'(rv), 32'h0);
    setReq(0, 1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
    setReq(1, 1'b1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0);
    #1;
    checkOutput("rst_first_gnt", {30'h0, r1_gnt, r0_gnt}, 32'h1);
    @(negedge clk);
    r0_req = 1'b0; r1_req = 1'b0;
    #1;
    waited = 0;
    while (!r0_rvalid && waited < 6) begin
      @(negedge clk); #1; waited++;
    end
    checkOutput("rst_first_rdata", r0_rdata, 32'h11223344);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
